muldiv_hilo: RTL and testbench
==============================

// Module: muldiv_hilo
// PURPOSE
//  Multi-cycle multiply/divide unit with architectural HI/LO registers for the 24-instruction CPU.
//  Replaces the single-cycle X*Y and X/Y paths; the ALU keeps shifts, add/sub and logic ops.
//  The decode stage issues a start pulse, stalls the pipeline while busy is high, then reads hi/lo (MFHI/MFLO).
//  MTHI/MTLO write HI/LO directly.
// PARAMETERS
//  WIDTH  32  operand and result width; iteration count equals WIDTH
// PORTS
//  clk      in   1      system clock, rising edge
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      issue the operation on op/x/y; accepted only when busy=0
//  op       in   2      operation: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO
//  x        in   WIDTH  rs operand (multiplicand / dividend / MT source)
//  y        in   WIDTH  rt operand (multiplier / divisor)
//  flush    in   1      synchronous cancel of the in-flight operation (exception/branch kill)
//  busy     out  1      iterative operation in flight; pipeline must stall on MFHI/MFLO/start
//  done     out  1      one-cycle pulse: hi/lo updated by a completed MULTU/DIVU
//  hi       out  WIDTH  HI register (product[2W-1:W] / remainder)
//  lo       out  WIDTH  LO register (product[W-1:0] / quotient)
// BEHAVIOUR
//  Reset (async, rst_n=0): hi=0, lo=0, busy=0, done=0; FSM enters IDLE; counter=0. Reset mid-operation discards it.
//  FSM states:
//   - IDLE -> MUL on start&op=00.
//   - IDLE -> DIV on start&op=01.
//   - MUL/DIV -> FIN when counter reaches WIDTH-1.
//   - FIN -> IDLE.
//  Accept edge E0:
//   - latch x and y into working registers; clear accumulator/partial remainder; busy=1 from E0.
//  Iterations:
//   - one bit per clock at edges E1..EW.
//   - MULTU: radix-2 shift-add, 2W-bit unsigned product.
//   - DIVU: restoring divide, 1 quotient bit per cycle, unsigned.
//  Completion at edge EW:
//   - {hi,lo} written; busy falls; done=1 for exactly the cycle after EW.
//   - Total latency is WIDTH cycles from accept to done.
//  MTHI/MTLO, busy=0:
//   - write hi (or lo) from x at E0; no busy, no done; the other register is unchanged.
//  Start while busy=1: ignored entirely (no queueing); hi/lo/in-flight op unaffected.
//  flush=1:
//   - busy=1: return to IDLE next edge; hi/lo keep pre-op values; no done.
//   - busy=0: start is ignored in that same cycle.
//   - flush has priority over start and over completion in the same cycle.
//  Divide by zero (y=0): runs full WIDTH cycles; result lo=all-ones, hi=x (natural restoring result, must match).
//  Arithmetic: all intermediate values unsigned; product exact in 2*WIDTH bits; no overflow flag.
//  hi/lo are held stable while busy=1 (old values visible until done).
// CONFIGURATION
//  Macro SIGNED_MULDIV_EN:
//   - Defined: op gains meaning via extra input port op_signed (1 bit).
//     - MULT: magnitudes are multiplied, then the 2W-bit product is negated if the signs differ.
//     - DIV: quotient sign = sign(x)^sign(y); remainder sign = sign(x), truncating toward zero.
//     - Sign fix-up takes one extra FIN cycle, so latency is WIDTH+1.
//     - Signed divide by zero: lo=all-ones, hi=x.
//     - Signed 0x80000000 / -1: lo=0x80000000, hi=0.
//   - Undefined: port op_signed absent; unsigned-only, latency WIDTH.
// STRUCTURE
//  Shared package muldiv_pkg:
//   - op encodings (OP_MULTU, OP_DIVU, OP_MTHI, OP_MTLO);
//   - FSM state typedef (IDLE, MUL, DIV, FIN);
//   - localparam CNT_W = $clog2(WIDTH).
//  One sub-module: muldiv_step, combinational single-iteration datapath.
//   - Inputs: mode, acc, operand regs. Outputs: next acc/remainder and quotient bit.
//  Top level holds FSM, counter, working regs, HI/LO.
// TESTING
//  1 Reset mid-MULTU (x=7,y=9, rst_n low at cycle 10) -> hi=0,lo=0,busy=0,done=0; no later done.
//  2 MULTU x=0xFFFFFFFF,y=0xFFFFFFFF -> done exactly 32 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001.
//  3 DIVU x=100,y=7 -> lo=14, hi=2. DIVU x=5,y=0 -> lo=0xFFFFFFFF, hi=5.
//  4 MTHI x=0x1234 then MTLO x=0xABCD (busy=0) -> hi=0x1234, lo=0xABCD next cycle, done never asserted.
//  5 DIVU issued; start MULTU with busy=1; flush in cycle 15 of a second op ->
//    first result correct; second start ignored; flushed op leaves hi/lo unchanged, no done.
//  6 SIGNED_MULDIV_EN: DIV x=-7,y=2 -> lo=-3, hi=-1; MULT x=-2,y=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; latency 33.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and sizes for the HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam int MD_WIDTH = 32;
   localparam int CNT_W    = $clog2(MD_WIDTH);

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_DIVU  = 2'b01,
      OP_MTHI  = 2'b10,
      OP_MTLO  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01,
      DIV  = 2'b10,
      FIN  = 2'b11
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one iteration of the shared datapath.
// Multiply: radix-2 shift-add on {acc, q}, q holds the multiplier bits still to consume.
// Divide: restoring step, q shifts dividend bits out of its MSB and quotient bits into its LSB.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH-1:0] acc_nx,
   output logic [WIDTH-1:0] q_nx
);

   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
   logic             qbit;

   // Both candidate results are formed; mode selects which one advances the registers.
   always_comb begin
      addend = q[0] ? m : '0;
      sum    = {1'b0, acc} + {1'b0, addend};
      rem_sh = {acc, q[WIDTH-1]};
      trial  = rem_sh - {1'b0, m};
      qbit   = ~trial[WIDTH];
      if (is_div) begin
         acc_nx = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
         q_nx   = {q[WIDTH-2:0], qbit};
      end else begin
         acc_nx = sum[WIDTH:1];
         q_nx   = {sum[0], q[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative MULTU/DIVU unit with architectural HI/LO registers.
// Build option SIGNED_MULDIV_EN adds the op_signed input and a sign fix-up cycle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO complete here in one edge
// MUL   | shift-add multiply, one multiplier bit per clock
// DIV   | restoring divide, one quotient bit per clock
// FIN   | unsigned build: done cycle, a new op may issue
//       | signed build: sign fix-up, still busy, hi/lo written at its edge
module muldiv_hilo
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
`ifdef SIGNED_MULDIV_EN
   input  logic             op_signed,
`endif
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] acc_q, q_q, m_q, hi_q, lo_q;
   logic [WIDTH-1:0] acc_nx, q_nx, x_mag, y_mag;
   logic             done_q, iter, last, accept, start_iter;

   assign iter       = (state_q == MUL) || (state_q == DIV);
   assign last       = iter && (cnt_q == CNT_W'(WIDTH - 1));
   assign accept     = start && !busy && !flush;
   assign start_iter = accept && ((op == OP_MULTU) || (op == OP_DIVU));

`ifdef SIGNED_MULDIV_EN
   logic             sa_q, sb_q, dz_q, div_q;
   logic [WIDTH-1:0] hi_fix, lo_fix;

   assign busy  = iter || (state_q == FIN);
   assign x_mag = (op_signed && x[WIDTH-1]) ? -x : x;
   assign y_mag = (op_signed && y[WIDTH-1]) ? -y : y;

   // Operand signs captured at accept; the iterations only ever see magnitudes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa_q  <= 1'b0;
         sb_q  <= 1'b0;
         dz_q  <= 1'b0;
         div_q <= 1'b0;
      end else if (start_iter) begin
         sa_q  <= op_signed && x[WIDTH-1];
         sb_q  <= op_signed && y[WIDTH-1];
         dz_q  <= (y == '0);
         div_q <= (op == OP_DIVU);
      end
   end

   // Divide by zero keeps the all-ones quotient; remainder follows the dividend sign, so hi=x.
   always_comb begin
      hi_fix = acc_q;
      lo_fix = q_q;
      if (!div_q) begin
         if (sa_q ^ sb_q) {hi_fix, lo_fix} = -{acc_q, q_q};
      end else begin
         if ((sa_q ^ sb_q) && !dz_q) lo_fix = -q_q;
         if (sa_q) hi_fix = -acc_q;
      end
   end
`else
   assign busy  = iter;
   assign x_mag = x;
   assign y_mag = y;
`endif

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div (state_q == DIV),
      .acc    (acc_q),
      .q      (q_q),
      .m      (m_q),
      .acc_nx (acc_nx),
      .q_nx   (q_nx)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state; flush wins over both start and completion.
   always_comb begin
      state_d = state_q;
      case (state_q)
         MUL, DIV: begin
            if (flush)     state_d = IDLE;
            else if (last) state_d = FIN;
         end
`ifdef SIGNED_MULDIV_EN
         FIN: state_d = IDLE;
`endif
         default: begin
            state_d = IDLE;
            if (accept && (op == OP_MULTU))     state_d = MUL;
            else if (accept && (op == OP_DIVU)) state_d = DIV;
         end
      endcase
   end

   // Working registers and iteration counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         q_q   <= '0;
         m_q   <= '0;
         cnt_q <= '0;
      end else if (start_iter) begin
         acc_q <= '0;
         q_q   <= x_mag;
         m_q   <= y_mag;
         cnt_q <= '0;
      end else if (iter && !flush) begin
         acc_q <= acc_nx;
         q_q   <= q_nx;
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Architectural HI/LO: direct moves when idle, results only on an unflushed completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept && (op == OP_MTHI)) hi_q <= x;
         if (accept && (op == OP_MTLO)) lo_q <= x;
`ifdef SIGNED_MULDIV_EN
         if ((state_q == FIN) && !flush) begin
            hi_q   <= hi_fix;
            lo_q   <= lo_fix;
            done_q <= 1'b1;
         end
`else
         if (last && !flush) begin
            hi_q   <= acc_nx;
            lo_q   <= q_nx;
            done_q <= 1'b1;
         end
`endif
      end
   end

   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: directed vectors for muldiv_hilo with a queue-based result scoreboard.
// Stimulus pushes the expected {hi, lo, done cycle}; the monitor checks every done pulse.
module tb_muldiv_hilo;
   import muldiv_pkg::*;

   localparam int W = 32;
`ifdef SIGNED_MULDIV_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = W;
`endif

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           due;
   } exp_t;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         flush = 1'b0;
   logic [1:0]   op    = 2'b00;
   logic [W-1:0] x     = '0;
   logic [W-1:0] y     = '0;
`ifdef SIGNED_MULDIV_EN
   logic         op_signed = 1'b0;
`endif
   logic         busy, done;
   logic [W-1:0] hi, lo;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc     = 0;
   int   n_pass  = 0;
   int   n_total = 0;

   muldiv_hilo #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
`ifdef SIGNED_MULDIV_EN
      .op_signed (op_signed),
`endif
      .x         (x),
      .y         (y),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      x     = a;
      y     = b;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic expect_res(input logic [W-1:0] eh, input logic [W-1:0] el);
      sb.push_back('{hi: eh, lo: el, due: cyc + LAT});
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 3 * LAT; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      chk(name, W'(sb.size()), '0);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation, on time.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_done: got done=1 with hi=%h lo=%h expected no done", hi, lo);
         end else begin
            mon_e = sb.pop_front();
            chk("res_hi", hi, mon_e.hi);
            chk("res_lo", lo, mon_e.lo);
            chk("latency_cycle", W'(cyc), W'(mon_e.due));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_hi", hi, '0);
      chk("rst_lo", lo, '0);
      chk("rst_busy", W'(busy), '0);
      chk("rst_done", W'(done), '0);
      @(negedge clk) rst_n = 1'b1;

      // reset in the middle of a MULTU wipes hi/lo and the op
      issue(OP_MTHI, 32'h55, '0);
      issue(OP_MTLO, 32'h66, '0);
      chk("pre_rst_hi", hi, 32'h55);
      chk("pre_rst_lo", lo, 32'h66);
      issue(OP_MULTU, 32'd7, 32'd9);
      repeat (8) @(negedge clk);
      chk("mid_busy", W'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_hi", hi, '0);
      chk("midrst_lo", lo, '0);
      chk("midrst_busy", W'(busy), '0);
      chk("midrst_done", W'(done), '0);
      @(negedge clk) rst_n = 1'b1;
      repeat (LAT + 8) @(negedge clk);
      chk("post_rst_busy", W'(busy), '0);

      // full-scale MULTU, latency and hi/lo hold while busy
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      expect_res(32'hFFFF_FFFE, 32'h0000_0001);
      chk("mul_busy", W'(busy), 1);
      repeat (10) @(negedge clk);
      chk("hold_hi", hi, '0);
      chk("hold_lo", lo, '0);
      drain("mul_drain");

      // DIVU, including divide by zero
      issue(OP_DIVU, 32'd100, 32'd7);
      expect_res(32'd2, 32'd14);
      drain("div_drain");
      issue(OP_DIVU, 32'd5, 32'd0);
      expect_res(32'd5, 32'hFFFF_FFFF);
      drain("div0_drain");

      // MTHI / MTLO touch only their own register
      issue(OP_MTHI, 32'h1234, '0);
      chk("mthi_hi", hi, 32'h1234);
      chk("mthi_lo", lo, 32'hFFFF_FFFF);
      chk("mthi_busy", W'(busy), '0);
      issue(OP_MTLO, 32'hABCD, '0);
      chk("mtlo_lo", lo, 32'hABCD);
      chk("mtlo_hi", hi, 32'h1234);
      repeat (3) @(negedge clk);

      // start while busy is ignored
      issue(OP_DIVU, 32'd1000, 32'd3);
      expect_res(32'd1, 32'd333);
      repeat (3) @(negedge clk);
      issue(OP_MULTU, 32'd5, 32'd6);
      drain("busy_start_drain");
      repeat (3) @(negedge clk);
      chk("after_ignored_hi", hi, 32'd1);
      chk("after_ignored_lo", lo, 32'd333);

      // flush in cycle 15 of an in-flight op
      issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
      repeat (14) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("flush_busy", W'(busy), '0);
      chk("flush_hi", hi, 32'd1);
      chk("flush_lo", lo, 32'd333);
      repeat (LAT + 5) @(negedge clk);
      chk("flush_hi_late", hi, 32'd1);

      // flush while idle blocks a same-cycle start
      @(negedge clk);
      start = 1'b1; op = OP_MTHI; x = 32'hDEAD; flush = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; flush = 1'b0;
      chk("idle_flush_mthi", hi, 32'd1);
      @(negedge clk);
      start = 1'b1; op = OP_MULTU; x = 32'd3; y = 32'd3; flush = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; flush = 1'b0;
      chk("idle_flush_mul_busy", W'(busy), '0);
      repeat (LAT + 5) @(negedge clk);

      // recovery after flushes
      issue(OP_MULTU, 32'h1234_5678, 32'h10);
      expect_res(32'h1, 32'h2345_6780);
      drain("recover_drain");

`ifdef SIGNED_MULDIV_EN
      op_signed = 1'b1;
      issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
      expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFD);
      drain("sdiv_drain");
      issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
      expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFA);
      drain("smul_drain");
      issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
      expect_res(32'h0, 32'h8000_0000);
      drain("sdiv_ovf_drain");
      issue(OP_DIVU, 32'hFFFF_FFF7, 32'd0);
      expect_res(32'hFFFF_FFF7, 32'hFFFF_FFFF);
      drain("sdiv0_drain");
      op_signed = 1'b0;
`endif

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
